// File: rtl/pwm_compare_stage_if.sv
// pwm_compare_stage_if: count/duty inputs and PWM status outputs of pwm_compare_stage; PWM_WRAP_COUNT_EN adds wrap_count
interface pwm_compare_stage_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] count;
    logic [WIDTH:0]   duty_in;
    logic             duty_load;
    logic             duty_busy;
    logic             wrap_pulse;
    logic             pwm_out;
`ifdef PWM_WRAP_COUNT_EN
    logic [7:0]       wrap_count;
    modport master (output count, duty_in, duty_load, input duty_busy, wrap_pulse, pwm_out, wrap_count);
    modport slave (input count, duty_in, duty_load, output duty_busy, wrap_pulse, pwm_out, wrap_count);
`else
    modport master (output count, duty_in, duty_load, input duty_busy, wrap_pulse, pwm_out);
    modport slave (input count, duty_in, duty_load, output duty_busy, wrap_pulse, pwm_out);
`endif
endinterface

// File: rtl/pwm_compare_stage.sv
// pwm_compare_stage: registered PWM compare whose duty only changes at count wrap; PWM_WRAP_COUNT_EN adds an 8-bit wrap counter
module pwm_compare_stage #(
    parameter int WIDTH      = 4,
    parameter int DUTY_RESET = 0
) (
    input logic                clk,
    input logic                rst,
    pwm_compare_stage_if.slave bus
);
    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [WIDTH:0]   DUTY_FULL = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0]   DUTY_RST  = (WIDTH+1)'(DUTY_RESET);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH:0]   shadow_q, shadow_d;
    logic [WIDTH:0]   duty_active_q, duty_active_d;
    logic [WIDTH:0]   duty_eff;
    logic             wrap, load;
    logic             duty_busy_q, duty_busy_d;
    logic             wrap_pulse_q, wrap_pulse_d;
    logic             pwm_out_q, pwm_out_d;
`ifdef PWM_WRAP_COUNT_EN
    logic [7:0]       wrap_count_q, wrap_count_d;
`endif

    // wrap detect, shadow capture in IDLE, hand-over of the shadow at wrap, and the compare
    always_comb begin
        wrap          = count_q == CNT_MAX && bus.count == '0;
        load          = state_q == IDLE && bus.duty_load;
        count_d       = bus.count;
        shadow_d      = load ? (bus.duty_in > DUTY_FULL ? DUTY_FULL : bus.duty_in) : shadow_q;
        state_d       = load ? PENDING : (state_q == PENDING && wrap) ? IDLE : state_q;
        duty_eff      = (state_q == PENDING && wrap) ? shadow_q : duty_active_q;
        duty_active_d = duty_eff;
        duty_busy_d   = state_d == PENDING;
        wrap_pulse_d  = wrap;
        pwm_out_d     = {1'b0, bus.count} < duty_eff;
`ifdef PWM_WRAP_COUNT_EN
        wrap_count_d  = wrap_count_q + 8'(wrap);
`endif
    end

    // all state and registered outputs; reset discards any pending duty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            count_q       <= '0;
            shadow_q      <= '0;
            duty_active_q <= DUTY_RST;
            duty_busy_q   <= 1'b0;
            wrap_pulse_q  <= 1'b0;
            pwm_out_q     <= 1'b0;
`ifdef PWM_WRAP_COUNT_EN
            wrap_count_q  <= '0;
`endif
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            shadow_q      <= shadow_d;
            duty_active_q <= duty_active_d;
            duty_busy_q   <= duty_busy_d;
            wrap_pulse_q  <= wrap_pulse_d;
            pwm_out_q     <= pwm_out_d;
`ifdef PWM_WRAP_COUNT_EN
            wrap_count_q  <= wrap_count_d;
`endif
        end
    end

    assign bus.duty_busy  = duty_busy_q;
    assign bus.wrap_pulse = wrap_pulse_q;
    assign bus.pwm_out    = pwm_out_q;
`ifdef PWM_WRAP_COUNT_EN
    assign bus.wrap_count = wrap_count_q;
`endif
endmodule

// File: tb/tb_pwm_compare_stage.sv
// tb_pwm_compare_stage: directed checks of duty hand-over at wrap, saturation, reset and count jumps
module tb_pwm_compare_stage;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cnt = 4'd10;
    int         checks = 0;
    int         errors = 0;

    pwm_compare_stage_if #(.WIDTH(4)) bus ();

    pwm_compare_stage #(.WIDTH(4), .DUTY_RESET(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic ld, input logic [4:0] d);
        bus.count     = cnt;
        bus.duty_load = ld;
        bus.duty_in   = d;
        @(posedge clk);
        #1;
        bus.duty_load = 1'b0;
        cnt           = cnt + 4'd1;
    endtask

    task automatic period(input string tag, input logic [15:0] ldm, input logic [4:0] dlo, input logic [4:0] dhi,
                          input logic [15:0] pe, input logic [15:0] be, input logic [15:0] we);
        logic [15:0] pm, bm, wm;
        for (int i = 0; i < 16; i++) begin
            step(ldm[i], i < 8 ? dlo : dhi);
            pm[i] = bus.pwm_out;
            bm[i] = bus.duty_busy;
            wm[i] = bus.wrap_pulse;
        end
        chk({tag, ".pwm"}, pm, pe);
        chk({tag, ".busy"}, bm, be);
        chk({tag, ".wrap"}, wm, we);
    endtask

    initial begin
        bus.count     = 4'd0;
        bus.duty_in   = 5'd0;
        bus.duty_load = 1'b0;
        // reset held over a running count, with a load request that must be ignored
        step(1'b0, 5'd0);
        step(1'b1, 5'd5);
        chk("rst_hold", {13'd0, bus.pwm_out, bus.duty_busy, bus.wrap_pulse}, 16'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 5'd0);
        chk("rst_wrap", {13'd0, bus.pwm_out, bus.duty_busy, bus.wrap_pulse}, 16'd0);
`ifdef PWM_WRAP_COUNT_EN
        chk("rst_wcnt", {8'd0, bus.wrap_count}, 16'd0);
`endif
        rst = 1'b0;
        period("p1", 16'h0000, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'h0000);
        period("p2", 16'h0000, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'h0001);
        // duty 5 loaded mid-period, applied from the next wrap
        period("t2a", 16'h0080, 5'd5, 5'd5, 16'h0000, 16'hFF80, 16'h0001);
        period("t2b", 16'h0000, 5'd0, 5'd0, 16'h001F, 16'h0000, 16'h0001);
        // full duty, saturated duty, zero duty
        period("t3a", 16'h0080, 5'd16, 5'd16, 16'h001F, 16'hFF80, 16'h0001);
        period("t3b", 16'h0000, 5'd0, 5'd0, 16'hFFFF, 16'h0000, 16'h0001);
        period("t3c", 16'h0080, 5'd20, 5'd20, 16'hFFFF, 16'hFF80, 16'h0001);
        period("t3d", 16'h0000, 5'd0, 5'd0, 16'hFFFF, 16'h0000, 16'h0001);
        period("t3e", 16'h0080, 5'd0, 5'd0, 16'hFFFF, 16'hFF80, 16'h0001);
        period("t3f", 16'h0000, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'h0001);
        // second load while pending is ignored, then accepted after the wrap
        period("t4a", 16'h0404, 5'd3, 5'd9, 16'h0000, 16'hFFFC, 16'h0001);
        period("t4b", 16'h0400, 5'd9, 5'd9, 16'h0007, 16'hFC00, 16'h0001);
        period("t4c", 16'h0000, 5'd0, 5'd0, 16'h01FF, 16'h0000, 16'h0001);
        // load in the wrap cycle: old duty this period, new duty from the next wrap
        period("t5a", 16'h0001, 5'd6, 5'd6, 16'h01FF, 16'hFFFF, 16'h0001);
        period("t5b", 16'h0000, 5'd0, 5'd0, 16'h003F, 16'h0000, 16'h0001);
        // count jumps 9->0 while pending: no wrap, duty stays pending
        for (int i = 0; i < 10; i++) step(i == 4, 5'd2);
        chk("jump_pre", {14'd0, bus.pwm_out, bus.duty_busy}, 16'h0001);
        cnt = 4'd0;
        step(1'b0, 5'd0);
        chk("jump", {13'd0, bus.pwm_out, bus.duty_busy, bus.wrap_pulse}, 16'h0006);
        for (int i = 0; i < 15; i++) step(1'b0, 5'd0);
        period("t6a", 16'h0000, 5'd0, 5'd0, 16'h0003, 16'h0000, 16'h0001);
        // reset while pending discards the loaded duty
        step(1'b1, 5'd8);
        step(1'b0, 5'd0);
        chk("pend_pre", {14'd0, bus.pwm_out, bus.duty_busy}, 16'h0003);
        rst = 1'b1;
        #1;
        chk("pend_rst", {13'd0, bus.pwm_out, bus.duty_busy, bus.wrap_pulse}, 16'd0);
        for (int i = 0; i < 14; i++) step(1'b0, 5'd0);
        rst = 1'b0;
`ifdef PWM_WRAP_COUNT_EN
        chk("wcnt0", {8'd0, bus.wrap_count}, 16'd0);
`endif
        period("t7a", 16'h0000, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'h0000);
        period("t7b", 16'h0000, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'h0001);
        period("t7c", 16'h0000, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'h0001);
        period("t7d", 16'h0000, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'h0001);
`ifdef PWM_WRAP_COUNT_EN
        chk("wcnt3", {8'd0, bus.wrap_count}, 16'd3);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
